// File: rtl/regseq_pkg.sv
// rtl/regseq_pkg.sv - opcodes and FSM state encoding for the register-file op sequencer
package regseq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MOV = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_WRITE = 2'd3
  } state_t;

  // NOP is the only opcode that reports a result without touching the register file.
  function automatic logic op_writes(input logic [2:0] op);
    return op != OP_NOP;
  endfunction

endpackage

// File: rtl/regseq_alu.sv
// rtl/regseq_alu.sv - combinational ALU for the op sequencer
// REGSEQ_SAT_EN: ADD saturates to all-ones on carry, SUB saturates to zero on borrow.
import regseq_pkg::*;

module regseq_alu #(
  parameter int DATA_W = 8
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // One extra bit so the top bit is carry for ADD and borrow for SUB.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    carry  = 1'b0;
    case (op)
      OP_ADD: begin
        carry = sum[DATA_W];
`ifdef REGSEQ_SAT_EN
        result = sum[DATA_W] ? {DATA_W{1'b1}} : sum[DATA_W-1:0];
`else
        result = sum[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        carry = diff[DATA_W];
`ifdef REGSEQ_SAT_EN
        result = diff[DATA_W] ? '0 : diff[DATA_W-1:0];
`else
        result = diff[DATA_W-1:0];
`endif
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_MOV:  result = a;
      OP_LDI:  result = imm;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// rtl/regfile_op_sequencer.sv - one-command-at-a-time ALU initiator for a 2R/1W register file
// REGSEQ_SAT_EN selects saturating ADD/SUB inside regseq_alu.
import regseq_pkg::*;

module regfile_op_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_rd,
  input  logic [ADDR_W-1:0] cmd_rs0,
  input  logic [ADDR_W-1:0] cmd_rs1,
  input  logic [DATA_W-1:0] cmd_imm,
  output logic [ADDR_W-1:0] rf_read_addr0,
  output logic [ADDR_W-1:0] rf_read_addr1,
  input  logic [DATA_W-1:0] rf_read_data0,
  input  logic [DATA_W-1:0] rf_read_data1,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              rf_write_enable,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_carry
);

  state_t state;
  state_t next_state;

  logic [2:0]        op_q;
  logic [ADDR_W-1:0] rd_q;
  logic [ADDR_W-1:0] rs0_q;
  logic [ADDR_W-1:0] rs1_q;
  logic [DATA_W-1:0] imm_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] result_q;
  logic              carry_q;

  logic [DATA_W-1:0] alu_result;
  logic              alu_carry;
  logic              accept;

  assign accept = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // No stall points once a command is accepted: fixed 4-cycle round trip.
  always_comb begin
    next_state      = state;
    cmd_ready       = 1'b0;
    rf_read_addr0   = '0;
    rf_read_addr1   = '0;
    rf_write_addr   = '0;
    rf_write_data   = '0;
    rf_write_enable = 1'b0;
    rsp_valid       = 1'b0;
    case (state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          next_state = S_READ;
        end
      end
      S_READ: begin
        rf_read_addr0 = rs0_q;
        rf_read_addr1 = rs1_q;
        next_state    = S_EXEC;
      end
      S_EXEC: begin
        rf_read_addr0 = rs0_q;
        rf_read_addr1 = rs1_q;
        next_state    = S_WRITE;
      end
      S_WRITE: begin
        rf_read_addr0   = rs0_q;
        rf_read_addr1   = rs1_q;
        rf_write_addr   = rd_q;
        rf_write_data   = result_q;
        rf_write_enable = op_writes(op_q);
        rsp_valid       = 1'b1;
        next_state      = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q  <= OP_ADD;
      rd_q  <= '0;
      rs0_q <= '0;
      rs1_q <= '0;
      imm_q <= '0;
    end else if (accept) begin
      op_q  <= cmd_op;
      rd_q  <= cmd_rd;
      rs0_q <= cmd_rs0;
      rs1_q <= cmd_rs1;
      imm_q <= cmd_imm;
    end
  end

  // Operands are captured before WRITE, so rd may alias rs0/rs1 and still see the old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
    end else if (state == S_READ) begin
      a_q <= rf_read_data0;
      b_q <= rf_read_data1;
    end
  end

  // result_q doubles as rsp_data: it changes only on the EXEC->WRITE edge, when rsp_valid rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q <= '0;
      carry_q  <= 1'b0;
    end else if (state == S_EXEC) begin
      result_q <= alu_result;
      carry_q  <= alu_carry;
    end
  end

  assign rsp_data  = result_q;
  assign rsp_carry = carry_q;

  regseq_alu #(
    .DATA_W (DATA_W)
  ) u_alu (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .imm    (imm_q),
    .result (alu_result),
    .carry  (alu_carry)
  );

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// tb/tb_regfile_op_sequencer.sv - directed bench pairing the sequencer with an 8x8 register file
module tb_regfile_op_sequencer;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_rd;
  logic [2:0] cmd_rs0;
  logic [2:0] cmd_rs1;
  logic [7:0] cmd_imm;
  logic [2:0] rf_read_addr0;
  logic [2:0] rf_read_addr1;
  logic [7:0] rf_read_data0;
  logic [7:0] rf_read_data1;
  logic [2:0] rf_write_addr;
  logic [7:0] rf_write_data;
  logic       rf_write_enable;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       rsp_carry;

  logic [7:0] rf [8];
  logic       rf_clear;
  int         we_count;
  int         n_asserts;
  int         n_fail;

  regfile_op_sequencer #(
    .DATA_W (8),
    .ADDR_W (3)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_op          (cmd_op),
    .cmd_rd          (cmd_rd),
    .cmd_rs0         (cmd_rs0),
    .cmd_rs1         (cmd_rs1),
    .cmd_imm         (cmd_imm),
    .rf_read_addr0   (rf_read_addr0),
    .rf_read_addr1   (rf_read_addr1),
    .rf_read_data0   (rf_read_data0),
    .rf_read_data1   (rf_read_data1),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rf_write_enable (rf_write_enable),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_carry       (rsp_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rf_read_data0 = rf[rf_read_addr0];
  assign rf_read_data1 = rf[rf_read_addr1];

  always @(posedge clk) begin
    if (rf_clear) begin
      for (int i = 0; i < 8; i++) rf[i] <= 8'h00;
      we_count <= 0;
    end else if (rf_write_enable) begin
      rf[rf_write_addr] <= rf_write_data;
      we_count <= we_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present a command at a negedge; returns 1 ns after the accepting posedge.
  task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs0,
                      input logic [2:0] rs1, input logic [7:0] imm);
    @(negedge clk);
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs0   = rs0;
    cmd_rs1   = rs1;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    chk("ready_before_send", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  // Follow an accepted command through READ/EXEC/WRITE and back to IDLE.
  task automatic complete(input string name, input logic [2:0] rd, input logic [2:0] rs0,
                          input logic [2:0] rs1, input logic is_write, input logic [7:0] exp_data,
                          input logic exp_carry, input logic keep_valid);
    int lat;
    if (!keep_valid) cmd_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    chk({name, ":read_addr0"}, 32'(rf_read_addr0), 32'(rs0));
    chk({name, ":read_addr1"}, 32'(rf_read_addr1), 32'(rs1));
    chk({name, ":ready_busy"}, 32'(cmd_ready), 32'd0);
    while (!rsp_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({name, ":rsp_latency"}, 32'(lat), 32'd3);
    chk({name, ":rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, ":rsp_data"}, 32'(rsp_data), 32'(exp_data));
    chk({name, ":rsp_carry"}, 32'(rsp_carry), 32'(exp_carry));
    chk({name, ":write_enable"}, 32'(rf_write_enable), 32'(is_write));
    chk({name, ":write_addr"}, 32'(rf_write_addr), 32'(rd));
    chk({name, ":write_data"}, 32'(rf_write_data), 32'(exp_data));
    @(negedge clk);
    chk({name, ":ready_idle"}, 32'(cmd_ready), 32'd1);
    chk({name, ":rsp_pulse_end"}, 32'(rsp_valid), 32'd0);
    chk({name, ":read_addr_idle"}, 32'(rf_read_addr0), 32'd0);
    chk({name, ":rsp_data_held"}, 32'(rsp_data), 32'(exp_data));
  endtask

  task automatic ldi(input logic [2:0] rd, input logic [7:0] imm);
    send(3'b110, rd, 3'd0, 3'd0, imm);
    complete("ldi", rd, 3'd0, 3'd0, 1'b1, imm, 1'b0, 1'b0);
  endtask

  initial begin
    int wc;
    n_asserts = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    rf_clear  = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'd0;
    cmd_rd    = 3'd0;
    cmd_rs0   = 3'd0;
    cmd_rs1   = 3'd0;
    cmd_imm   = 8'h00;
    repeat (2) @(negedge clk);
    chk("reset:cmd_ready", 32'(cmd_ready), 32'd1);
    chk("reset:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset:rsp_data", 32'(rsp_data), 32'd0);
    chk("reset:rsp_carry", 32'(rsp_carry), 32'd0);
    chk("reset:write_enable", 32'(rf_write_enable), 32'd0);
    chk("reset:read_addr0", 32'(rf_read_addr0), 32'd0);
    rf_clear = 1'b0;
    rst_n    = 1'b1;

    // 1: LDI/LDI/ADD without carry
    ldi(3'd1, 8'h25);
    ldi(3'd2, 8'h13);
    send(3'b000, 3'd3, 3'd1, 3'd2, 8'h00);
    complete("add_basic", 3'd3, 3'd1, 3'd2, 1'b1, 8'h38, 1'b0, 1'b0);
    chk("add_basic:r3", 32'(rf[3]), 32'h38);

    // 2: ADD with carry out
    ldi(3'd1, 8'hF0);
    ldi(3'd2, 8'h20);
    send(3'b000, 3'd4, 3'd1, 3'd2, 8'h00);
`ifdef REGSEQ_SAT_EN
    complete("add_carry", 3'd4, 3'd1, 3'd2, 1'b1, 8'hFF, 1'b1, 1'b0);
    chk("add_carry:r4", 32'(rf[4]), 32'hFF);
`else
    complete("add_carry", 3'd4, 3'd1, 3'd2, 1'b1, 8'h10, 1'b1, 1'b0);
    chk("add_carry:r4", 32'(rf[4]), 32'h10);
`endif

    // 3: SUB with borrow
    ldi(3'd1, 8'h05);
    ldi(3'd2, 8'h09);
    send(3'b001, 3'd5, 3'd1, 3'd2, 8'h00);
`ifdef REGSEQ_SAT_EN
    complete("sub_borrow", 3'd5, 3'd1, 3'd2, 1'b1, 8'h00, 1'b1, 1'b0);
    chk("sub_borrow:r5", 32'(rf[5]), 32'h00);
`else
    complete("sub_borrow", 3'd5, 3'd1, 3'd2, 1'b1, 8'hFC, 1'b1, 1'b0);
    chk("sub_borrow:r5", 32'(rf[5]), 32'hFC);
`endif

    // 4: XOR r1,r1,r1 with a second command (MOV r7,r2) held valid while busy
    ldi(3'd1, 8'hA5);
    send(3'b100, 3'd1, 3'd1, 3'd1, 8'h00);
    cmd_op  = 3'b101;
    cmd_rd  = 3'd7;
    cmd_rs0 = 3'd2;
    cmd_rs1 = 3'd0;
    complete("xor_alias", 3'd1, 3'd1, 3'd1, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("xor_alias:r1", 32'(rf[1]), 32'h00);
    chk("xor_alias:r7_untouched", 32'(rf[7]), 32'h00);
    @(posedge clk);
    #1;
    complete("mov_held", 3'd7, 3'd2, 3'd0, 1'b1, 8'h09, 1'b0, 1'b0);
    chk("mov_held:r7", 32'(rf[7]), 32'h09);

    // 5: NOP leaves the register file alone
    wc = we_count;
    send(3'b111, 3'd3, 3'd1, 3'd2, 8'h77);
    complete("nop", 3'd3, 3'd1, 3'd2, 1'b0, 8'h00, 1'b0, 1'b0);
    chk("nop:write_count", 32'(we_count), 32'(wc));
    chk("nop:r3", 32'(rf[3]), 32'h38);

    // 6: reset during EXEC of ADD r6 aborts the operation
    wc = we_count;
    send(3'b000, 3'd6, 3'd2, 3'd2, 8'h00);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort:rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort:write_enable", 32'(rf_write_enable), 32'd0);
    chk("abort:read_addr0", 32'(rf_read_addr0), 32'd0);
    chk("abort:rsp_data", 32'(rsp_data), 32'd0);
    chk("abort:rsp_carry", 32'(rsp_carry), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort:ready_after", 32'(cmd_ready), 32'd1);
    chk("abort:rsp_valid_after", 32'(rsp_valid), 32'd0);
    chk("abort:r6", 32'(rf[6]), 32'h00);
    chk("abort:write_count", 32'(we_count), 32'(wc));

    // Sequencer is usable again after the abort
    send(3'b011, 3'd6, 3'd2, 3'd3, 8'h00);
    complete("or_after_reset", 3'd6, 3'd2, 3'd3, 1'b1, 8'h39, 1'b0, 1'b0);
    chk("or_after_reset:r6", 32'(rf[6]), 32'h39);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
